pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register. It generalises the fixed ID/EX latch into a reusable stage for IF/ID, ID/EX, EX/MEM and MEM/WB. The stage adds valid/ready handshaking, stall, synchronous flush with control-field bubbling, and an optional skid slot that breaks the combinational ready path. It sits between any two CPU stages, and the enclosing stage wrappers pack their fields into the data/ctrl vectors.

---
 rtl/pipe_pkg.sv | 64 ++++++
 rtl/pipe_slot.sv | 39 +++
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 tb/tb_pipe_stage_reg.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: default
// widths for the ID/EX instance, control-bundle bit positions, and the
// field layout the stage wrappers use to pack the ID/EX payload.
package pipe_pkg;

  localparam int CTRL_W_IDEX = 11;
  localparam int DATA_W_IDEX = 192;

  // Control bundle bit positions (MSB first).
  localparam int CTRL_MEMWRITE   = 10;
  localparam int CTRL_MEMREAD    = 9;
  localparam int CTRL_MEMTOREG   = 8;
  localparam int CTRL_ALUSRC     = 7;
  localparam int CTRL_REGWRITE   = 6;
  localparam int CTRL_BRANCH     = 5;
  localparam int CTRL_ALUCTL_MSB = 4;
  localparam int CTRL_ALUCTL_LSB = 0;

  // ID/EX payload field offsets (LSB of each field).
  localparam int IDEX_OPCODE_LSB = 0;    // 7 bits
  localparam int IDEX_FUNCT7_LSB = 7;    // 7 bits
  localparam int IDEX_FUNCT3_LSB = 14;   // 3 bits
  localparam int IDEX_RD_LSB     = 17;   // 5 bits
  localparam int IDEX_RS2_LSB    = 22;   // 5 bits
  localparam int IDEX_RS1_LSB    = 27;   // 5 bits
  localparam int IDEX_PC4_LSB    = 32;   // 32 bits
  localparam int IDEX_PC_LSB     = 64;   // 32 bits
  localparam int IDEX_IMM_LSB    = 96;   // 32 bits
  localparam int IDEX_RD2_LSB    = 128;  // 32 bits
  localparam int IDEX_RD1_LSB    = 160;  // 32 bits

  // Packed view of the ID/EX payload; declaration order matches the offsets.
  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  opcode;
  } idex_data_t;

  // Next-state action for the main output register of a stage.
  typedef enum logic [2:0] {
    OP_HOLD      = 3'd0,
    OP_FLUSH     = 3'd1,
    OP_FROM_SKID = 3'd2,
    OP_FROM_IN   = 3'd3,
    OP_DRAIN     = 3'd4
  } main_op_t;

  function automatic logic [DATA_W_IDEX-1:0] pack_idex(input idex_data_t f);
    return f;
  endfunction

  function automatic idex_data_t unpack_idex(input logic [DATA_W_IDEX-1:0] v);
    return idex_data_t'(v);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: valid bit, payload and control bundle.
// Clear wins over load. Control reads as zero whenever the slot is empty,
// so a bubble can never carry a live RegWrite or MemWrite.
module pipe_slot #(
  parameter int DATA_W = 192,
  parameter int CTRL_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic [CTRL_W-1:0] ctrl_q;

  // Slot register: clear drops the beat and zeroes control, payload is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= 1'b0;
      data   <= '0;
      ctrl_q <= '0;
    end else if (clear) begin
      valid  <= 1'b0;
      ctrl_q <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      data   <= d_data;
      ctrl_q <= d_ctrl;
    end
  end

  assign ctrl = valid ? ctrl_q : '0;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between two CPU stages, with stall, flush
// (control bubbling) and an optional skid slot that registers in_ready.
//
// Handshake: a beat moves on the upstream side when in_valid & in_ready
// and on the downstream side when out_valid & out_ready, both sampled at
// the rising clk edge. A valid beat is held stable until it is consumed.
// With SKID=0, in_ready depends combinationally on out_ready; with SKID=1
// it depends only on flops plus stall/flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_IDEX,
  parameter int CTRL_W = CTRL_W_IDEX,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              accept;
  logic              drain;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  main_op_t          main_op;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      logic skid_clear;

      // A beat arriving while main is held and not draining parks in skid;
      // skid empties into main on the first drain.
      assign in_ready   = ~stall & ~flush & ~skid_valid;
      assign skid_load  = ~flush & accept & out_valid & ~drain;
      assign skid_clear = flush | (skid_valid & drain);

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .valid  (skid_valid),
        .data   (skid_data),
        .ctrl   (skid_ctrl)
      );
    end else begin : g_noskid
      assign in_ready   = ~stall & ~flush & (~out_valid | out_ready);
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
    end
  endgenerate

  // Main register action in priority order; with no skid slot the skid
  // term is never taken and accept already implies ~out_valid | drain.
  always_comb begin
    main_op = OP_HOLD;
    if (flush)
      main_op = OP_FLUSH;
    else if (skid_valid & drain)
      main_op = OP_FROM_SKID;
    else if (accept & (~out_valid | drain))
      main_op = OP_FROM_IN;
    else if (drain)
      main_op = OP_DRAIN;
  end

  assign main_load   = (main_op == OP_FROM_SKID) | (main_op == OP_FROM_IN);
  assign main_clear  = (main_op == OP_FLUSH) | (main_op == OP_DRAIN);
  assign main_d_data = (main_op == OP_FROM_SKID) ? skid_data : in_data;
  assign main_d_ctrl = (main_op == OP_FROM_SKID) ? skid_ctrl : in_ctrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load),
    .clear  (main_clear),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .valid  (out_valid),
    .data   (out_data),
    .ctrl   (out_ctrl)
  );

  // Both terms are flops, so the held-beat count is glitch-free.
  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

  // Count cycles where downstream was ready but got nothing; saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bubble_cnt <= '0;
    else if (~out_valid & out_ready & (bubble_cnt != {CNT_W{1'b1}}))
      bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 instance and a SKID=0, CNT_W=4 instance
// share one input stream; each has its own expected-beat queue.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = DATA_W_IDEX;
  localparam int CW = CTRL_W_IDEX;
  localparam int W  = DW + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid, stall, flush, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          ir1, ov1, ir0, ov0;
  logic [DW-1:0] od1, od0;
  logic [CW-1:0] oc1, oc0;
  logic [1:0]    occ1, occ0;
  logic [15:0]   bc1;
  logic [3:0]    bc0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
    .occupancy(occ1), .bubble_cnt(bc1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
    .occupancy(occ0), .bubble_cnt(bc0)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic st, input logic fl, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q0[$];

  // Drains are compared before this cycle's accept is queued; a flush
  // discards everything held, a reset loses everything.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      exp_q1.delete();
      exp_q0.delete();
    end else begin
      if (ov1 && out_ready) begin
        if (exp_q1.size() == 0) check("sb1_unexpected_beat", {oc1, od1}, '0);
        else begin
          e = exp_q1.pop_front();
          check("sb1_beat", {oc1, od1}, e);
        end
      end
      if (ov0 && out_ready) begin
        if (exp_q0.size() == 0) check("sb0_unexpected_beat", {oc0, od0}, '0);
        else begin
          e = exp_q0.pop_front();
          check("sb0_beat", {oc0, od0}, e);
        end
      end
      if (!ov1) check("bubble_ctrl1", W'(oc1), '0);
      if (!ov0) check("bubble_ctrl0", W'(oc0), '0);
      if (flush) begin
        exp_q1.delete();
        exp_q0.delete();
      end else begin
        if (in_valid && ir1) exp_q1.push_back({in_ctrl, in_data});
        if (in_valid && ir0) exp_q0.push_back({in_ctrl, in_data});
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic [10:0] c;
    logic       ordy;
    logic       rdy1;
    logic       ov1;
    logic [1:0] occ1;
    logic       rdy0;
    logic       ov0;
  } vec_t;

  vec_t vt[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] b0;
    int n_acc0;

    // stream 1..4 with out_ready high, then backpressure A/B into the skid
    vt[0] = '{1'b1, 8'h01, 11'h041, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1};
    vt[1] = '{1'b1, 8'h02, 11'h042, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1};
    vt[2] = '{1'b1, 8'h03, 11'h7ff, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1};
    vt[3] = '{1'b1, 8'h04, 11'h400, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1};
    vt[4] = '{1'b0, 8'h00, 11'h000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 8'h11, 11'h011, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1};
    vt[6] = '{1'b1, 8'h22, 11'h022, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    vt[7] = '{1'b1, 8'h99, 11'h099, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1};
    vt[8] = '{1'b0, 8'h00, 11'h000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
    vt[9] = '{1'b0, 8'h00, 11'h000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0};

    // reset state
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_ov1", W'(ov1), '0);
    check("rst_od1", W'(od1), '0);
    check("rst_oc1", W'(oc1), '0);
    check("rst_occ1", W'(occ1), '0);
    check("rst_bc1", W'(bc1), '0);
    check("rst_ov0", W'(ov0), '0);
    check("rst_bc0", W'(bc0), '0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].iv, {{(DW-8){1'b0}}, vt[i].d}, vt[i].c, 1'b0, 1'b0, vt[i].ordy);
      #1;
      check("tbl_in_ready1", W'(ir1), W'(vt[i].rdy1));
      check("tbl_in_ready0", W'(ir0), W'(vt[i].rdy0));
      tick();
      check("tbl_out_valid1", W'(ov1), W'(vt[i].ov1));
      check("tbl_occupancy1", W'(occ1), W'(vt[i].occ1));
      check("tbl_out_valid0", W'(ov0), W'(vt[i].ov0));
    end

    // flush: A held, B presented with flush, then C
    drive(1'b1, DW'(8'h0a), 11'h440, 1'b0, 1'b0, 1'b0);
    tick();
    check("fl_hold_a1", W'(ov1), W'(1'b1));
    drive(1'b1, DW'(8'h0b), 11'h440, 1'b0, 1'b1, 1'b0);
    #1;
    check("fl_in_ready1", W'(ir1), '0);
    check("fl_in_ready0", W'(ir0), '0);
    tick();
    check("fl_out_valid1", W'(ov1), '0);
    check("fl_out_ctrl1", W'(oc1), '0);
    check("fl_occupancy1", W'(occ1), '0);
    check("fl_out_valid0", W'(ov0), '0);
    check("fl_out_ctrl0", W'(oc0), '0);
    drive(1'b1, DW'(8'h33), 11'h041, 1'b0, 1'b0, 1'b1);
    #1;
    check("fl_c_in_ready1", W'(ir1), W'(1'b1));
    tick();
    check("fl_c_valid1", W'(ov1), W'(1'b1));
    check("fl_c_data1", W'(od1), W'(8'h33));
    check("fl_c_ctrl1", W'(oc1), W'(11'h041));
    check("fl_c_valid0", W'(ov0), W'(1'b1));
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    check("fl_c_gone1", W'(ov1), '0);

    // stall: held beat drains once, then two bubbles are counted
    drive(1'b1, DW'(8'h44), 11'h044, 1'b0, 1'b0, 1'b0);
    tick();
    b0 = bc1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, DW'(8'h55), 11'h055, 1'b1, 1'b0, 1'b1);
      #1;
      check("st_in_ready1", W'(ir1), '0);
      check("st_in_ready0", W'(ir0), '0);
      tick();
      check("st_out_valid1", W'(ov1), '0);
    end
    check("st_bubble_cnt1", W'(bc1), W'(b0 + 16'd2));

    // async reset with two beats held
    drive(1'b1, DW'(8'h66), 11'h066, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, DW'(8'h77), 11'h077, 1'b0, 1'b0, 1'b0);
    tick();
    check("ar_occ_full1", W'(occ1), W'(2'd2));
    check("ar_occ0", W'(occ0), W'(2'd1));
    #2;
    reset = 1'b1;
    #1;
    check("ar_ov1", W'(ov1), '0);
    check("ar_od1", W'(od1), '0);
    check("ar_oc1", W'(oc1), '0);
    check("ar_occ1", W'(occ1), '0);
    check("ar_bc1", W'(bc1), '0);
    check("ar_ov0", W'(ov0), '0);
    check("ar_occ0_zero", W'(occ0), '0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("ar_in_ready1", W'(ir1), W'(1'b1));

    // SKID=0: combinational ready, then out_ready toggling
    drive(1'b1, DW'(8'h80), 11'h080, 1'b0, 1'b0, 1'b1);
    tick();
    check("s0_loaded", W'(ov0), W'(1'b1));
    out_ready = 1'b0;
    #1;
    check("s0_ready_low", W'(ir0), '0);
    out_ready = 1'b1;
    #1;
    check("s0_ready_high", W'(ir0), W'(1'b1));
    n_acc0 = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid  = 1'b1;
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      in_ctrl   = CW'($urandom());
      out_ready = (k % 2 == 1);
      #1;
      if (ir0) n_acc0++;
      tick();
    end
    check("s0_half_rate", W'(n_acc0), W'(4));

    // idle with out_ready high: everything drains, small counter saturates
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    repeat (20) tick();
    check("s0_bubble_sat", W'(bc0), W'(4'd15));
    check("end_ov1", W'(ov1), '0);
    check("end_ov0", W'(ov0), '0);
    check("end_q1_empty", W'(exp_q1.size()), '0);
    check("end_q0_empty", W'(exp_q0.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
